// File: rtl/spr_core_mc.sv
// spr_core_mc: multi-channel subpixel-rendering core.
// Each channel turns a (2*PPC+1)-sample window into PPC subpixels per clock
// by blending prev/curr with a weight picked from the local edge shape.
// Fixed 3-stage pipeline, no back-pressure; syncs travel alongside the data.
module spr_core_mc #(
  parameter int              N_CH       = 2,
  parameter int              PPC        = 2,
  parameter int              DW         = 12,
  parameter int              WW         = 14,
  parameter int              TW         = 12,
  parameter int              W_DEF      = 8192,
  parameter logic [N_CH-1:0] BORDER_PAR = 2'b10
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_valid,
  input  logic                         i_hs,
  input  logic                         i_vs,
  input  logic                         en,
  input  logic                         spr_seperate_case,
  input  logic [N_CH*TW-1:0]           spr_thr_edge,
  input  logic [N_CH*WW-1:0]           pValue2_edge,
  input  logic [N_CH*WW-1:0]           pValue3_edge,
  input  logic [N_CH*WW-1:0]           pValue4_edge,
  input  logic [N_CH*WW-1:0]           pValue5_edge,
  input  logic [N_CH*WW-1:0]           pValue_border,
  input  logic [N_CH*(2*PPC+1)*DW-1:0] i_pix,
  output logic                         o_valid,
  output logic                         o_hs,
  output logic                         o_vs,
  output logic                         o_line_odd,
  output logic [N_CH*PPC*(DW-1)-1:0]   o_pix
);

  // Samples per channel window, output width, accumulator and rounding widths.
  localparam int NS = 2*PPC + 1;
  localparam int OW = DW - 1;
  localparam int AW = DW + WW + 1;
  localparam int RW = AW + 1;
  // Common width for comparing a sample difference against the threshold.
  localparam int CW = (DW > TW) ? DW : TW;

  localparam logic [WW-1:0] W_DEF_W = WW'(W_DEF);
  // Unity weight 2^WW; the curr weight is W_ONE - w.
  localparam logic [WW:0]   W_ONE   = {1'b1, {WW{1'b0}}};
  // Rounding offset 2^WW added before the >> (WW+1).
  localparam logic [RW-1:0] RND     = RW'(W_ONE);
  // Largest representable output code.
  localparam logic [RW-1:0] SAT_MAX = RW'({OW{1'b1}});

  // ---------------------------------------------------------------------
  // Line state derived from the syncs
  // ---------------------------------------------------------------------
  logic hs_prev_reg;
  logic line_odd_reg;
  logic first_pend_reg;
  logic hs_rise;

  assign hs_rise = i_hs & ~hs_prev_reg;

  // Track line parity and whether the first active beat of a line is pending.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hs_prev_reg    <= 1'b0;
      line_odd_reg   <= 1'b0;
      first_pend_reg <= 1'b1;
    end else begin
      hs_prev_reg <= i_hs;
      if (i_vs) begin
        // Vertical blanking wins over any coincident hsync edge.
        line_odd_reg   <= 1'b0;
        first_pend_reg <= 1'b1;
      end else if (hs_rise) begin
        line_odd_reg   <= ~line_odd_reg;
        first_pend_reg <= 1'b1;
      end else if (i_valid && !i_hs) begin
        first_pend_reg <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Sideband delay line, matched to the 3 data stages
  // ---------------------------------------------------------------------
  logic [2:0] valid_pipe_reg;
  logic [2:0] hs_pipe_reg;
  logic [2:0] vs_pipe_reg;
  logic [2:0] odd_pipe_reg;

  // Shift valid/syncs/parity through three stages alongside the data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_pipe_reg <= '0;
      hs_pipe_reg    <= '0;
      vs_pipe_reg    <= '0;
      odd_pipe_reg   <= '0;
    end else begin
      valid_pipe_reg <= {valid_pipe_reg[1:0], i_valid};
      hs_pipe_reg    <= {hs_pipe_reg[1:0], i_hs};
      vs_pipe_reg    <= {vs_pipe_reg[1:0], i_vs};
      odd_pipe_reg   <= {odd_pipe_reg[1:0], line_odd_reg};
    end
  end

  assign o_valid    = valid_pipe_reg[2];
  assign o_hs       = hs_pipe_reg[2];
  assign o_vs       = vs_pipe_reg[2];
  assign o_line_odd = odd_pipe_reg[2];

  // ---------------------------------------------------------------------
  // Per-channel, per-subpixel datapath
  // ---------------------------------------------------------------------
  genvar gi, gj;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [TW-1:0] thr;
      logic [WW-1:0] w2;
      logic [WW-1:0] w3;
      logic [WW-1:0] w4;
      logic [WW-1:0] w5;
      logic [WW-1:0] wb;
      logic          border_ok;

      assign thr = spr_thr_edge[gi*TW +: TW];
      assign w2  = pValue2_edge[gi*WW +: WW];
      assign w3  = pValue3_edge[gi*WW +: WW];
      assign w4  = pValue4_edge[gi*WW +: WW];
      assign w5  = pValue5_edge[gi*WW +: WW];
      assign wb  = pValue_border[gi*WW +: WW];

      // Border applies to the first active beat of lines whose parity
      // matches this channel's border parity bit.
      assign border_ok = first_pend_reg && i_valid &&
                         (BORDER_PAR[gi] == line_odd_reg);

      for (gj = 0; gj < PPC; gj++) begin : g_out
        localparam int   BASE      = gi*NS + 2*gj;
        localparam logic FIRST_OUT = (gj == 0) ? 1'b1 : 1'b0;

        logic [DW-1:0] prev_s;
        logic [DW-1:0] curr_s;
        logic [DW-1:0] next_s;
        logic [DW-1:0] diff_l;
        logic [DW-1:0] diff_r;
        logic          edge_l;
        logic          edge_r;
        logic          is_orig;
        logic          is_border;
        logic          pass;
        logic [WW-1:0] w_sel;
        logic [DW-1:0] prev_op;

        // Stage registers
        logic [DW-1:0] prev_s1_reg;
        logic [DW-1:0] curr_s1_reg;
        logic [WW-1:0] w_s1_reg;
        logic          pass_s1_reg;
        logic [AW-1:0] mac;
        logic [AW-1:0] acc_s2_reg;
        logic [OW-1:0] half_s2_reg;
        logic          pass_s2_reg;
        logic [RW-1:0] rnd;
        logic [RW-1:0] shifted;
        logic [OW-1:0] blended;
        logic [OW-1:0] pix_s3_reg;

        // Adjacent outputs share the sample between them.
        assign prev_s = i_pix[(BASE+0)*DW +: DW];
        assign curr_s = i_pix[(BASE+1)*DW +: DW];
        assign next_s = i_pix[(BASE+2)*DW +: DW];

        // Classify the window and pick the blend weight and prev operand.
        always_comb begin
          diff_l    = (curr_s >= prev_s) ? (curr_s - prev_s) : (prev_s - curr_s);
          diff_r    = (curr_s >= next_s) ? (curr_s - next_s) : (next_s - curr_s);
          edge_l    = CW'(diff_l) > CW'(thr);
          edge_r    = CW'(diff_r) > CW'(thr);
          is_orig   = (prev_s == curr_s) && (curr_s == next_s);
          is_border = FIRST_OUT && border_ok;
          pass      = 1'b0;
          w_sel     = W_DEF_W;
          prev_op   = prev_s;
          if (!en) begin
            pass = 1'b1;
          end else if (is_border) begin
            prev_op = '0;
            w_sel   = wb;
          end else if (is_orig) begin
            pass = 1'b1;
          end else if (spr_seperate_case) begin
            if (edge_l && !edge_r) begin
              w_sel = (curr_s > prev_s) ? w2 : w3;
            end else if (!edge_l && edge_r) begin
              w_sel = w4;
            end else if (edge_l && edge_r) begin
              w_sel = w5;
            end
          end
        end

        // S1: capture classification result, weight and operands.
        always_ff @(posedge clk) begin
          if (!rst_n) begin
            prev_s1_reg <= '0;
            curr_s1_reg <= '0;
            w_s1_reg    <= '0;
            pass_s1_reg <= 1'b0;
          end else begin
            prev_s1_reg <= prev_op;
            curr_s1_reg <= curr_s;
            w_s1_reg    <= w_sel;
            pass_s1_reg <= pass;
          end
        end

        // Weighted sum; products cannot exceed 2^(DW+WW), so AW bits suffice.
        always_comb begin
          mac = AW'(prev_s1_reg) * AW'(w_s1_reg) +
                AW'(curr_s1_reg) * AW'(W_ONE - {1'b0, w_s1_reg});
        end

        // S2: register the accumulator and the pass-through half value.
        always_ff @(posedge clk) begin
          if (!rst_n) begin
            acc_s2_reg  <= '0;
            half_s2_reg <= '0;
            pass_s2_reg <= 1'b0;
          end else begin
            acc_s2_reg  <= mac;
            half_s2_reg <= curr_s1_reg[DW-1:1];
            pass_s2_reg <= pass_s1_reg;
          end
        end

        // Round to nearest, scale back to the output range and clamp.
        always_comb begin
          rnd     = {1'b0, acc_s2_reg} + RND;
          shifted = rnd >> (WW + 1);
          blended = (shifted > SAT_MAX) ? SAT_MAX[OW-1:0] : shifted[OW-1:0];
        end

        // S3: final subpixel, either the blended or the pass-through value.
        always_ff @(posedge clk) begin
          if (!rst_n) begin
            pix_s3_reg <= '0;
          end else begin
            pix_s3_reg <= pass_s2_reg ? half_s2_reg : blended;
          end
        end

        assign o_pix[(gi*PPC+gj)*OW +: OW] = pix_s3_reg;
      end
    end
  endgenerate

endmodule

// File: tb/tb_spr_core_mc.sv
// Directed testbench for spr_core_mc (N_CH=2, PPC=2, DW=12, WW=14).
// Expected beats are queued when driven and checked 3 clocks later.
module tb_spr_core_mc;

  localparam int NCH = 2;
  localparam int PPCT = 2;
  localparam int DWT = 12;
  localparam int WWT = 14;
  localparam int TWT = 12;
  localparam int PIXW = NCH*PPCT*(DWT-1);

  logic                    clk;
  logic                    rst_n;
  logic                    valid;
  logic                    hs;
  logic                    vs;
  logic                    en;
  logic                    sep;
  logic [NCH*TWT-1:0]      thr;
  logic [NCH*WWT-1:0]      w2;
  logic [NCH*WWT-1:0]      w3;
  logic [NCH*WWT-1:0]      w4;
  logic [NCH*WWT-1:0]      w5;
  logic [NCH*WWT-1:0]      wb;
  logic [NCH*5*DWT-1:0]    pix_in;
  logic                    o_valid;
  logic                    o_hs;
  logic                    o_vs;
  logic                    o_line_odd;
  logic [PIXW-1:0]         o_pix;

  typedef struct packed {
    logic            v;
    logic            hs;
    logic            vs;
    logic            odd;
    logic            chk;
    logic [PIXW-1:0] pix;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    checks;
  int    errors;

  spr_core_mc dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_valid           (valid),
    .i_hs              (hs),
    .i_vs              (vs),
    .en                (en),
    .spr_seperate_case (sep),
    .spr_thr_edge      (thr),
    .pValue2_edge      (w2),
    .pValue3_edge      (w3),
    .pValue4_edge      (w4),
    .pValue5_edge      (w5),
    .pValue_border     (wb),
    .i_pix             (pix_in),
    .o_valid           (o_valid),
    .o_hs              (o_hs),
    .o_vs              (o_vs),
    .o_line_odd        (o_line_odd),
    .o_pix             (o_pix)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pack expected subpixels: channel 0 out 0/1, channel 1 out 0/1.
  function automatic logic [PIXW-1:0] pk(input int c0k0, input int c0k1,
                                         input int c1k0, input int c1k1);
    pk = {11'(c1k1), 11'(c1k0), 11'(c0k1), 11'(c0k0)};
  endfunction

  task automatic set_ch(input int c, input int s0, input int s1, input int s2,
                        input int s3, input int s4);
    int s[5];
    s = '{s0, s1, s2, s3, s4};
    for (int i = 0; i < 5; i++) pix_in[(c*5+i)*DWT +: DWT] = 12'(s[i]);
  endtask

  task automatic set_sa();
    set_ch(0, 777, 2000, 2000, 2000, 2000);
    set_ch(1, 1000, 3000, 3000, 3000, 3000);
  endtask

  task automatic chk(input string tag, input string what,
                     input logic [PIXW-1:0] got, input logic [PIXW-1:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s %s got %h expected %h", tag, what, got, want);
    end
  endtask

  // One clock: queue the expectation for the beat on the inputs, clock it,
  // then compare whatever beat has reached the output.
  task automatic step(input string tag, input logic eodd, input logic echk,
                      input logic [PIXW-1:0] epix);
    exp_t  e;
    string t;
    if (!rst_n) begin
      exp_q.delete();
      tag_q.delete();
      e = '0;
      e.chk = 1'b1;
      for (int i = 0; i < 3; i++) begin
        exp_q.push_back(e);
        tag_q.push_back($sformatf("%s_rst%0d", tag, i));
      end
    end else begin
      e.v   = valid;
      e.hs  = hs;
      e.vs  = vs;
      e.odd = eodd;
      e.chk = echk;
      e.pix = epix;
      exp_q.push_back(e);
      tag_q.push_back(tag);
    end
    @(posedge clk);
    #1;
    if (exp_q.size() >= 3) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      $display("[%0t] txn %s valid=%b hs=%b vs=%b odd=%b pix=%h", $time, t,
               o_valid, o_hs, o_vs, o_line_odd, o_pix);
      chk(t, "o_valid", PIXW'(o_valid), PIXW'(e.v));
      chk(t, "o_hs", PIXW'(o_hs), PIXW'(e.hs));
      chk(t, "o_vs", PIXW'(o_vs), PIXW'(e.vs));
      chk(t, "o_line_odd", PIXW'(o_line_odd), PIXW'(e.odd));
      if (e.chk) chk(t, "o_pix", o_pix, e.pix);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    valid  = 1'b0;
    hs     = 1'b0;
    vs     = 1'b0;
    en     = 1'b1;
    sep    = 1'b1;
    thr    = {12'd100, 12'd100};
    w2     = {14'd4096, 14'd4096};
    w3     = {14'd10000, 14'd12288};
    w4     = {14'd3000, 14'd2048};
    w5     = {14'd16000, 14'd12000};
    wb     = {14'd8192, 14'd8192};
    pix_in = '0;

    step("reset", 1'b0, 1'b0, '0);
    rst_n = 1'b1;
    step("idle0", 1'b0, 1'b0, '0);

    // Frame start, then line 0 (even): channel 0 border on first beat.
    vs = 1'b1; step("vs_on", 1'b0, 1'b0, '0);
    vs = 1'b0; step("vs_off", 1'b0, 1'b0, '0);
    set_sa(); valid = 1'b1;
    step("l0_b0_border_ch0", 1'b0, 1'b1, pk(500, 1000, 1250, 1500));
    step("l0_b1_normal", 1'b0, 1'b1, pk(847, 1000, 1250, 1500));

    // Line 1 (odd): channel 1 border on first beat.
    valid = 1'b0; hs = 1'b1; step("hs1_on", 1'b0, 1'b0, '0);
    hs = 1'b0; step("hs1_off", 1'b1, 1'b0, '0);
    valid = 1'b1;
    step("l1_b0_border_ch1", 1'b1, 1'b1, pk(847, 1000, 750, 1500));
    step("l1_b1_normal", 1'b1, 1'b1, pk(847, 1000, 1250, 1500));
    sep = 1'b0;
    step("l1_sep0_default", 1'b1, 1'b1, pk(694, 1000, 1000, 1500));
    sep = 1'b1;

    // Original windows and saturation at the strict threshold.
    set_ch(0, 2222, 2222, 2222, 2222, 2222);
    set_ch(1, 4095, 4095, 0, 0, 0);
    thr = {12'd4095, 12'd100};
    step("l1_orig_sat", 1'b1, 1'b1, pk(1111, 1111, 2047, 0));
    thr = {12'd100, 12'd100};

    // pValue3 / pValue4 / pValue5 selections.
    set_ch(0, 3000, 1000, 1050, 1000, 3000);
    set_ch(1, 3000, 1000, 500, 500, 500);
    step("l1_w3_w4_w5", 1'b1, 1'b1, pk(1250, 503, 1477, 250));

    // Line 2 (even): bypass on the would-be border beat, then normal.
    valid = 1'b0; hs = 1'b1; step("hs2_on", 1'b1, 1'b0, '0);
    hs = 1'b0; step("hs2_off", 1'b0, 1'b0, '0);
    set_ch(0, 0, 3001, 50, 999, 999);
    set_ch(1, 4095, 4095, 4095, 4095, 4095);
    valid = 1'b1; en = 1'b0;
    step("l2_bypass", 1'b0, 1'b1, pk(1500, 499, 2047, 2047));
    en = 1'b1;
    step("l2_after_bypass", 1'b0, 1'b1, pk(402, 381, 2047, 2047));

    // Line 3 (odd), then vsync and hsync rising together.
    valid = 1'b0; hs = 1'b1; step("hs3_on", 1'b0, 1'b0, '0);
    hs = 1'b0; step("hs3_off", 1'b1, 1'b0, '0);
    set_sa(); valid = 1'b1;
    step("l3_b0_border_ch1", 1'b1, 1'b1, pk(847, 1000, 750, 1500));
    valid = 1'b0; vs = 1'b1; hs = 1'b1;
    step("vs_hs_together", 1'b1, 1'b0, '0);
    hs = 1'b0; step("vs_hold", 1'b0, 1'b0, '0);
    vs = 1'b0; step("vs_end", 1'b0, 1'b0, '0);
    valid = 1'b1;
    step("f2_b0_border_ch0", 1'b0, 1'b1, pk(500, 1000, 1250, 1500));
    step("f2_b1_normal", 1'b0, 1'b1, pk(847, 1000, 1250, 1500));

    // Reset while beats are in flight.
    rst_n = 1'b0; step("midreset", 1'b0, 1'b0, '0);
    rst_n = 1'b1;
    step("post_rst_b0_border", 1'b0, 1'b1, pk(500, 1000, 1250, 1500));
    step("post_rst_b1_normal", 1'b0, 1'b1, pk(847, 1000, 1250, 1500));

    valid = 1'b0;
    for (int i = 0; i < 3; i++) step("flush", 1'b0, 1'b0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
